round_controller: RTL and testbench
===================================

ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 Parameter WIN_SCORE, default 5, round wins that end the match; legal range 1..9.
REQ-002 Parameter COUNT_TICKS, default 3, tick pulses spent in COUNTDOWN; legal range 1..15.
REQ-003 Parameter END_TICKS, default 2, tick pulses spent in ROUND_END; legal range 1..15.
REQ-004 clk  in  1  sole clock; all state changes on posedge clk.
REQ-005 clear_b  in  1  asynchronous active-low reset; acts on negedge clear_b.
REQ-006 start  in  1  level sampled per cycle; begins a match from IDLE or MATCH_OVER.
REQ-007 tick  in  1  one-cycle frame-rate enable; paces COUNTDOWN and ROUND_END.
REQ-008 crash_p1  in  1  player 1 hit a trail or wall this cycle.
REQ-009 crash_p2  in  1  player 2 hit a trail or wall this cycle.
REQ-010 run  out  1  high only in PLAY; gates player movement.
REQ-011 clear_arena  out  1  one-cycle pulse commanding the arena wipe.
REQ-012 countdown  out  4  remaining COUNTDOWN ticks; 0 outside COUNTDOWN.
REQ-013 score1, score2  out  4 each  unsigned binary round wins, 0..9, feeding the hex displays.
REQ-014 round_result  out  2  00 none, 01 p1 won, 10 p2 won, 11 draw.
REQ-015 match_over  out  1  high only in MATCH_OVER.
REQ-016 state  out  3  IDLE=0, COUNTDOWN=1, PLAY=2, ROUND_END=3, MATCH_OVER=4.

Function
REQ-017 The FSM SHALL have exactly the five states of REQ-016; codes 5..7 SHALL go to IDLE on the next clk.
REQ-018 IDLE with start=1 SHALL enter COUNTDOWN next cycle and assert clear_arena for that one transition cycle.
REQ-019 Entering COUNTDOWN SHALL load countdown=COUNT_TICKS.
REQ-020 Each tick in COUNTDOWN SHALL decrement countdown; the tick that takes it from 1 to 0 SHALL enter PLAY.
REQ-021 In PLAY, crash_p1=1 and crash_p2=0 SHALL increment score2, set round_result=10 and enter ROUND_END.
REQ-022 In PLAY, crash_p2=1 and crash_p1=0 SHALL increment score1, set round_result=01 and enter ROUND_END.
REQ-023 In PLAY, crash_p1=crash_p2=1 in the same cycle SHALL be a draw: no score change, round_result=11, enter ROUND_END.
REQ-024 Score and round_result updates SHALL occur on the same edge that leaves PLAY (zero added latency).
REQ-025 Crash inputs SHALL be ignored outside PLAY; tick SHALL be ignored in PLAY, IDLE and MATCH_OVER.
REQ-026 Scores SHALL saturate at 9 and never wrap.
REQ-027 ROUND_END SHALL wait END_TICKS tick pulses using an internal counter.
REQ-028 On the last tick, if score1 or score2 equals WIN_SCORE, the FSM SHALL enter MATCH_OVER.
REQ-029 Otherwise the FSM SHALL enter COUNTDOWN with a one-cycle clear_arena pulse.
REQ-030 round_result SHALL hold through ROUND_END and MATCH_OVER and clear to 00 on entering COUNTDOWN.
REQ-031 MATCH_OVER with start=1 SHALL clear both scores to 0, pulse clear_arena, and enter COUNTDOWN next cycle.
REQ-032 start SHALL be ignored in COUNTDOWN, PLAY and ROUND_END.
REQ-033 run, match_over and countdown SHALL be registered outputs decoded from the current state.

Reset
REQ-034 clear_b=0 SHALL immediately, regardless of clk, force state=IDLE, score1=score2=0, round_result=00, countdown=0, run=0, clear_arena=0, match_over=0, internal tick counters=0.
REQ-035 Reset asserted mid-PLAY or mid-ROUND_END SHALL discard any pending score update.
REQ-036 After clear_b rises, the block SHALL remain in IDLE until start=1 is sampled.

Verification (WIN_SCORE=2, COUNT_TICKS=3, END_TICKS=2)
REQ-037 Run start pulse in IDLE, then 3 ticks -> clear_arena high 1 cycle; countdown reads 3,2,1; state=PLAY with run=1 on the edge of the third tick.
REQ-038 Single crash: in PLAY, crash_p1=1 for one cycle -> next cycle score2=1, round_result=10, run=0; after 2 ticks, COUNTDOWN with clear_arena pulse and round_result=00.
REQ-039 Draw: crash_p1=crash_p2=1 in one PLAY cycle -> scores unchanged, round_result=11.
REQ-040 Match over: p2 crashes twice -> score1=2, then after 2 ticks match_over=1, state=4.
REQ-041 Restart: start in MATCH_OVER -> score1=score2=0, clear_arena pulse, state=COUNTDOWN.
REQ-042 Ignored inputs: crash during COUNTDOWN leaves scores unchanged; start during PLAY is ignored.
REQ-043 Mid-operation reset: clear_b low between clk edges mid-ROUND_END -> all outputs at reset values before the next edge.

Source files
------------

// File: rtl/round_controller.sv
// Match/round sequencer for a two-player light-cycle game: paces countdown,
// play and round-end phases on frame ticks and keeps saturating round scores.
module round_controller #(
    parameter int WIN_SCORE   = 5,
    parameter int COUNT_TICKS = 3,
    parameter int END_TICKS   = 2
) (
    input  logic       clk,
    input  logic       clear_b,
    input  logic       start,
    input  logic       tick,
    input  logic       crash_p1,
    input  logic       crash_p2,
    output logic       run,
    output logic       clear_arena,
    output logic [3:0] countdown,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] round_result,
    output logic       match_over,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COUNTDOWN  = 3'd1,
        ST_PLAY       = 3'd2,
        ST_ROUND_END  = 3'd3,
        ST_MATCH_OVER = 3'd4
    } state_t;

    localparam logic [3:0] COUNT_INIT = 4'(COUNT_TICKS);
    localparam logic [3:0] END_INIT   = 4'(END_TICKS);
    localparam logic [3:0] WIN        = 4'(WIN_SCORE);
    localparam logic [3:0] SCORE_MAX  = 4'd9;

    state_t     state_reg, state_next;
    logic [3:0] count_reg, count_next;
    logic [3:0] end_reg, end_next;
    logic [3:0] score1_reg, score1_next;
    logic [3:0] score2_reg, score2_next;
    logic [1:0] result_reg, result_next;
    logic       clear_reg, clear_next;
    logic       run_reg, match_over_reg;

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        end_next    = end_reg;
        score1_next = score1_reg;
        score2_next = score2_reg;
        result_next = result_reg;
        clear_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next  = ST_COUNTDOWN;
                    count_next  = COUNT_INIT;
                    result_next = 2'b00;
                    clear_next  = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (tick) begin
                    if (count_reg <= 4'd1) begin
                        state_next = ST_PLAY;
                        count_next = 4'd0;
                    end else begin
                        count_next = count_reg - 4'd1;
                    end
                end
            end
            ST_PLAY: begin
                // The crashing player loses the round; a simultaneous crash is a draw.
                if (crash_p1 || crash_p2) begin
                    state_next  = ST_ROUND_END;
                    end_next    = END_INIT;
                    result_next = {crash_p1, crash_p2};
                    if (crash_p1 && !crash_p2 && score2_reg < SCORE_MAX)
                        score2_next = score2_reg + 4'd1;
                    if (crash_p2 && !crash_p1 && score1_reg < SCORE_MAX)
                        score1_next = score1_reg + 4'd1;
                end
            end
            ST_ROUND_END: begin
                if (tick) begin
                    if (end_reg <= 4'd1) begin
                        end_next = 4'd0;
                        if (score1_reg == WIN || score2_reg == WIN) begin
                            state_next = ST_MATCH_OVER;
                        end else begin
                            state_next  = ST_COUNTDOWN;
                            count_next  = COUNT_INIT;
                            result_next = 2'b00;
                            clear_next  = 1'b1;
                        end
                    end else begin
                        end_next = end_reg - 4'd1;
                    end
                end
            end
            ST_MATCH_OVER: begin
                if (start) begin
                    state_next  = ST_COUNTDOWN;
                    count_next  = COUNT_INIT;
                    score1_next = 4'd0;
                    score2_next = 4'd0;
                    result_next = 2'b00;
                    clear_next  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = 4'd0;
                end_next   = 4'd0;
            end
        endcase
    end

    // Phase-decoded outputs are registered from the next state so they line up with state.
    always_ff @(posedge clk or negedge clear_b) begin
        if (!clear_b) begin
            state_reg      <= ST_IDLE;
            count_reg      <= 4'd0;
            end_reg        <= 4'd0;
            score1_reg     <= 4'd0;
            score2_reg     <= 4'd0;
            result_reg     <= 2'b00;
            clear_reg      <= 1'b0;
            run_reg        <= 1'b0;
            match_over_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            end_reg        <= end_next;
            score1_reg     <= score1_next;
            score2_reg     <= score2_next;
            result_reg     <= result_next;
            clear_reg      <= clear_next;
            run_reg        <= (state_next == ST_PLAY);
            match_over_reg <= (state_next == ST_MATCH_OVER);
        end
    end

    assign run          = run_reg;
    assign match_over   = match_over_reg;
    assign clear_arena  = clear_reg;
    assign countdown    = count_reg;
    assign score1       = score1_reg;
    assign score2       = score2_reg;
    assign round_result = result_reg;
    assign state        = state_reg;

endmodule

// File: tb/tb_round_controller.sv
// Randomized bench for round_controller: a phase/score reference model predicts
// every output each cycle; asynchronous resets are injected, mostly mid-ROUND_END.
module tb_round_controller;

    localparam int WIN   = 2;
    localparam int COUNT = 3;
    localparam int ENDT  = 2;
    localparam int NCYC  = 4000;

    logic       clk;
    logic       clear_b;
    logic       start;
    logic       tick;
    logic       crash_p1;
    logic       crash_p2;
    logic       run;
    logic       clear_arena;
    logic [3:0] countdown;
    logic [3:0] score1;
    logic [3:0] score2;
    logic [1:0] round_result;
    logic       match_over;
    logic [2:0] state;

    round_controller #(
        .WIN_SCORE  (WIN),
        .COUNT_TICKS(COUNT),
        .END_TICKS  (ENDT)
    ) dut (
        .clk         (clk),
        .clear_b     (clear_b),
        .start       (start),
        .tick        (tick),
        .crash_p1    (crash_p1),
        .crash_p2    (crash_p2),
        .run         (run),
        .clear_arena (clear_arena),
        .countdown   (countdown),
        .score1      (score1),
        .score2      (score2),
        .round_result(round_result),
        .match_over  (match_over),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: phase number, ticks left in the phase, per-player wins.
    int m_phase;
    int m_left;
    int m_wins[2];
    int m_result;
    int m_wipe;
    int n_rounds  = 0;
    int n_matches = 0;
    int n_resets  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_left   = 0;
        m_wins[0] = 0;
        m_wins[1] = 0;
        m_result = 0;
        m_wipe   = 0;
    endtask

    task automatic new_round();
        m_phase  = 1;
        m_left   = COUNT;
        m_result = 0;
        m_wipe   = 1;
    endtask

    task automatic model_step(input int st, input int tk, input int c1, input int c2);
        m_wipe = 0;
        case (m_phase)
            0: if (st != 0) new_round();
            1: if (tk != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) m_phase = 2;
            end
            2: if (c1 + c2 > 0) begin
                m_result = 2 * c1 + c2;
                if (m_result == 1) m_wins[0] = (m_wins[0] >= 9) ? 9 : m_wins[0] + 1;
                if (m_result == 2) m_wins[1] = (m_wins[1] >= 9) ? 9 : m_wins[1] + 1;
                m_phase = 3;
                m_left  = ENDT;
                n_rounds++;
                $display("round %0d: result=%0d score %0d-%0d", n_rounds, m_result, m_wins[0], m_wins[1]);
            end
            3: if (tk != 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    if (m_wins[0] == WIN || m_wins[1] == WIN) begin
                        m_phase = 4;
                        n_matches++;
                        $display("match %0d over: score %0d-%0d", n_matches, m_wins[0], m_wins[1]);
                    end else begin
                        new_round();
                    end
                end
            end
            4: if (st != 0) begin
                m_wins[0] = 0;
                m_wins[1] = 0;
                new_round();
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic check_outputs(input string pfx);
        check_eq({pfx, ".state"}, 32'(state), 32'(m_phase));
        check_eq({pfx, ".run"}, 32'(run), 32'(m_phase == 2));
        check_eq({pfx, ".match_over"}, 32'(match_over), 32'(m_phase == 4));
        check_eq({pfx, ".countdown"}, 32'(countdown), 32'((m_phase == 1) ? m_left : 0));
        check_eq({pfx, ".clear_arena"}, 32'(clear_arena), 32'(m_wipe));
        check_eq({pfx, ".score1"}, 32'(score1), 32'(m_wins[0]));
        check_eq({pfx, ".score2"}, 32'(score2), 32'(m_wins[1]));
        check_eq({pfx, ".round_result"}, 32'(round_result), 32'(m_result));
    endtask

    initial begin
        int st, tk, c1, c2;
        clear_b  = 1'b0;
        start    = 1'b0;
        tick     = 1'b0;
        crash_p1 = 1'b0;
        crash_p2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        clear_b = 1'b1;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check_outputs("cycle");
            if ((m_phase == 3 && $urandom_range(0, 39) == 0) || $urandom_range(0, 599) == 0) begin
                // Reset lands between edges; outputs must clear without a clock.
                n_resets++;
                $display("async reset %0d in phase %0d", n_resets, m_phase);
                clear_b = 1'b0;
                #2;
                model_reset();
                check_outputs("async_reset");
                @(posedge clk);
                #2;
                clear_b = 1'b1;
                continue;
            end
            st = ($urandom_range(0, 3) == 0) ? 1 : 0;
            tk = ($urandom_range(0, 2) == 0) ? 1 : 0;
            c1 = ($urandom_range(0, 9) == 0) ? 1 : 0;
            c2 = ($urandom_range(0, 9) == 0) ? 1 : 0;
            start    = st[0];
            tick     = tk[0];
            crash_p1 = c1[0];
            crash_p2 = c2[0];
            model_step(st, tk, c1, c2);
        end

        @(negedge clk);
        check_outputs("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
